// File: rtl/alu16_sequencer_pkg.sv
// Shared types and constants for the 16-bit arithmetic sequencer.
//   - Flag bit positions inside the 4-bit ZNHC nibble
//   - 16-bit request opcodes, sequencer states, 8-bit ALU opcodes
//   - compose_flags(): packs individual Z/N/H/C bits into a nibble
package alu16_sequencer_pkg;

    localparam int unsigned F_Z = 3;
    localparam int unsigned F_N = 2;
    localparam int unsigned F_H = 1;
    localparam int unsigned F_C = 0;

    typedef enum logic [1:0] {
        Alu16Add   = 2'd0,
        Alu16Inc   = 2'd1,
        Alu16Dec   = 2'd2,
        Alu16AddSp = 2'd3
    } alu16_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLow  = 2'd1,
        StHigh = 2'd2,
        StDone = 2'd3
    } alu16_state_e;

    typedef enum logic [2:0] {
        AluPass0 = 3'd0,
        AluAdd   = 3'd1,
        AluAdc   = 3'd2,
        AluSub   = 3'd3,
        AluSbc   = 3'd4
    } alu_op_e;

    function automatic logic [3:0] compose_flags(input logic z, input logic n,
                                                 input logic h, input logic c);
        logic [3:0] f;
        f      = 4'h0;
        f[F_Z] = z;
        f[F_N] = n;
        f[F_H] = h;
        f[F_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/alu16_sequencer_alu.sv
// Combinational 8-bit ALU used for the two byte passes of a 16-bit operation.
// Ports:
//   op         in   operation (PASS0 / ADD / ADC / SUB / SBC)
//   a, b       in   8-bit operands
//   carry_in   in   carry (ADC) or borrow (SBC) input
//   result     out  8-bit result
//   half_carry out  carry/borrow out of bit 3
//   carry      out  carry/borrow out of bit 7
module alu16_sequencer_alu
    import alu16_sequencer_pkg::*;
(
    input  alu_op_e     op,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        carry_in,
    output logic [7:0]  result,
    output logic        half_carry,
    output logic        carry
);

    // One extra bit on each sum catches the carry (or borrow, via wrap) out.
    logic [8:0] full;
    logic [4:0] nib;

    always_comb begin
        full = 9'h000;
        nib  = 5'h00;
        unique case (op)
            AluAdd: begin
                full = {1'b0, a} + {1'b0, b};
                nib  = {1'b0, a[3:0]} + {1'b0, b[3:0]};
            end
            AluAdc: begin
                full = {1'b0, a} + {1'b0, b} + {8'h00, carry_in};
                nib  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'h0, carry_in};
            end
            AluSub: begin
                full = {1'b0, a} - {1'b0, b};
                nib  = {1'b0, a[3:0]} - {1'b0, b[3:0]};
            end
            AluSbc: begin
                full = {1'b0, a} - {1'b0, b} - {8'h00, carry_in};
                nib  = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'h0, carry_in};
            end
            default: begin
                full = 9'h000;
                nib  = 5'h00;
            end
        endcase
    end

    assign result     = full[7:0];
    assign half_carry = nib[4];
    assign carry      = full[8];

endmodule

// File: rtl/alu16_sequencer.sv
// Sequences one 16-bit arithmetic request (ADD HL,rr / INC rr / DEC rr / ADD SP,e) as two
// 8-bit passes through a private ALU and returns the result with ZNHC flags.
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_op, req_a, req_b  opcode and operands, captured on accept
//   req_flags             current ZNHC flags, captured on accept
//   rsp_valid/rsp_ready   response handshake (valid held until ready)
//   rsp_data, rsp_flags   16-bit result and resulting ZNHC flags
module alu16_sequencer
    import alu16_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [3:0]  req_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [3:0]  rsp_flags
);

    alu16_state_e state_q;
    alu16_op_e    op_q;
    logic [15:0]  a_q;
    logic [15:0]  b_q;
    logic [3:0]   flags_q;
    logic [7:0]   lo_q;
    logic         h_lo_q;
    logic         c_lo_q;

    alu_op_e      alu_op;
    logic [7:0]   alu_a;
    logic [7:0]   alu_b;
    logic         alu_cin;
    logic [7:0]   alu_result;
    logic         alu_h;
    logic         alu_c;
    logic [3:0]   done_flags;

    alu16_sequencer_alu u_alu (
        .op         (alu_op),
        .a          (alu_a),
        .b          (alu_b),
        .carry_in   (alu_cin),
        .result     (alu_result),
        .half_carry (alu_h),
        .carry      (alu_c)
    );

    // ALU input mux; idle/done states park the ALU on PASS0 with zero operands.
    always_comb begin
        alu_op  = AluPass0;
        alu_a   = 8'h00;
        alu_b   = 8'h00;
        alu_cin = 1'b0;
        unique case (state_q)
            StLow: begin
                alu_a = a_q[7:0];
                unique case (op_q)
                    Alu16Add, Alu16AddSp: begin
                        alu_op = AluAdd;
                        alu_b  = b_q[7:0];
                    end
                    Alu16Inc: begin
                        alu_op = AluAdd;
                        alu_b  = 8'h01;
                    end
                    Alu16Dec: begin
                        alu_op = AluSub;
                        alu_b  = 8'h01;
                    end
                endcase
            end
            StHigh: begin
                alu_a = a_q[15:8];
                unique case (op_q)
                    Alu16Add: begin
                        alu_op  = AluAdc;
                        alu_b   = b_q[15:8];
                        alu_cin = c_lo_q;
                    end
                    Alu16Inc: begin
                        alu_op  = AluAdc;
                        alu_cin = c_lo_q;
                    end
                    Alu16AddSp: begin
                        alu_op  = AluAdc;
                        alu_b   = {8{b_q[7]}};
                        alu_cin = c_lo_q;
                    end
                    Alu16Dec: begin
                        // Borrow into the high byte only when the low byte wrapped 00 -> FF.
                        alu_op  = AluSbc;
                        alu_cin = (a_q[7:0] == 8'h00);
                    end
                endcase
            end
            default: ;
        endcase
    end

    // Result flags are composed here; the ALU only contributes H/C.
    always_comb begin
        done_flags = flags_q;
        unique case (op_q)
            Alu16Add:           done_flags = compose_flags(flags_q[F_Z], 1'b0, alu_h, alu_c);
            Alu16Inc, Alu16Dec: done_flags = flags_q;
            Alu16AddSp:         done_flags = compose_flags(1'b0, 1'b0, h_lo_q, c_lo_q);
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            op_q      <= Alu16Add;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            flags_q   <= 4'h0;
            lo_q      <= 8'h00;
            h_lo_q    <= 1'b0;
            c_lo_q    <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 16'h0000;
            rsp_flags <= 4'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        op_q      <= alu16_op_e'(req_op);
                        a_q       <= req_a;
                        b_q       <= req_b;
                        flags_q   <= req_flags;
                        req_ready <= 1'b0;
                        state_q   <= StLow;
                    end
                end
                StLow: begin
                    lo_q    <= alu_result;
                    h_lo_q  <= alu_h;
                    c_lo_q  <= alu_c;
                    state_q <= StHigh;
                end
                StHigh: begin
                    rsp_data  <= {alu_result, lo_q};
                    rsp_flags <= done_flags;
                    rsp_valid <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    // A request arriving with rsp_ready waits for the idle bubble.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule
